asteroide_uc: RTL

Control unit (FSM) for the asteroid datapath (`asteroide`); it sequences that datapath's counter, muxes, add/subtract unit and both slot memories.
- On start: clears all 16 asteroid slots.
- On each frame tick: sweeps every slot, moves live asteroids one cell per their opcode and checks ship collision.
- After the sweep: services a latched spawn request by loading a ROM-random asteroid into the first free slot.
- Sits between the game top-level FSM and `asteroide`.

---
 rtl/asteroide_pkg.sv | 31 +++
 rtl/asteroide_uc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/asteroide_pkg.sv
// Shared types and constants for the asteroide control unit: state codes as driven on
// db_estado, position-mux selects and asteroid direction opcodes.
package asteroide_pkg;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    LIMPA      = 4'd1,
    ESPERA     = 4'd2,
    LE         = 4'd3,
    MOVE       = 4'd4,
    CHECA      = 4'd5,
    COLIDE     = 4'd6,
    PROXIMO    = 4'd7,
    SP_LE      = 4'd8,
    SP_ROM     = 4'd9,
    SP_ESCREVE = 4'd10,
    FIM        = 4'd11,
    GAME_OVER  = 4'd12
  } estado_t;

  localparam logic [1:0] POS_SOMA_X = 2'b00;
  localparam logic [1:0] POS_SOMA_Y = 2'b01;
  localparam logic [1:0] POS_RANDOM = 2'b10;
  localparam logic [1:0] POS_HOLD   = 2'b11;

  localparam logic [1:0] OP_X_MAIS  = 2'b00;
  localparam logic [1:0] OP_X_MENOS = 2'b01;
  localparam logic [1:0] OP_Y_MAIS  = 2'b10;
  localparam logic [1:0] OP_Y_MENOS = 2'b11;

endpackage

// File: rtl/asteroide_uc.sv
// Control FSM for the asteroide datapath: clears slots, sweeps/moves asteroids, checks ship
// collision and services spawn requests. Define ASTE_COLISAO_DESTROI_EN for lives/destroy mode.
module asteroide_uc
  import asteroide_pkg::*;
#(
  parameter int N_SLOTS   = 16,
  parameter int VIDAS_INI = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tick_frame,
  input  logic       pedido_spawn,
  input  logic       colisao_aste_com_nave,
  input  logic       rco_contador_aste,
  input  logic [1:0] opcode_aste,
  input  logic       loaded_aste,
  input  logic       destruido_aste,
  output logic       conta_contador_aste,
  output logic       reset_contador_aste,
  output logic [1:0] select_mux_pos_aste,
  output logic       select_mux_coor_aste,
  output logic       select_soma_sub_aste,
  output logic       enable_mem_aste,
  output logic       enable_load_aste,
  output logic       new_load_aste,
  output logic       new_destruido_aste,
  output logic       reset_reg_nave,
  output logic       reset_gerador_random,
  output logic       pronto_frame,
  output logic       fim_jogo,
  output logic [1:0] vidas,
  output logic [3:0] db_estado
);

  // The slot counter is 4 bits and vidas is 2 bits; other values are not supported.
  if (N_SLOTS != 16 || VIDAS_INI < 1 || VIDAS_INI > 3) begin : g_config_invalida
  end

  estado_t estado, prox;
  logic    spawn_pend;
  logic    limpa_spawn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  // A new request wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      spawn_pend <= 1'b0;
    else if (pedido_spawn && estado != INICIAL && estado != LIMPA)
      spawn_pend <= 1'b1;
    else if (limpa_spawn)
      spawn_pend <= 1'b0;
  end

`ifdef ASTE_COLISAO_DESTROI_EN
  logic [1:0] vidas_r;
  logic       dec_vidas;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 vidas_r <= '0;
    else if (estado == INICIAL) vidas_r <= 2'(VIDAS_INI);
    else if (dec_vidas)         vidas_r <= vidas_r - 2'd1;
  end

  assign vidas = vidas_r;
`else
  assign vidas = '0;
`endif

  assign db_estado = estado;

  always_comb begin
    prox                 = estado;
    limpa_spawn          = 1'b0;
    conta_contador_aste  = 1'b0;
    reset_contador_aste  = 1'b0;
    select_mux_pos_aste  = POS_SOMA_X;
    select_mux_coor_aste = 1'b0;
    select_soma_sub_aste = 1'b0;
    enable_mem_aste      = 1'b0;
    enable_load_aste     = 1'b0;
    new_load_aste        = 1'b0;
    new_destruido_aste   = 1'b0;
    reset_reg_nave       = 1'b0;
    reset_gerador_random = 1'b0;
    pronto_frame         = 1'b0;
    fim_jogo             = 1'b0;
`ifdef ASTE_COLISAO_DESTROI_EN
    dec_vidas            = 1'b0;
`endif
    unique case (estado)
      INICIAL: begin
        // Gated by reset so every output reads 0 while reset is asserted.
        reset_contador_aste  = reset;
        reset_reg_nave       = reset;
        reset_gerador_random = reset;
        limpa_spawn          = 1'b1;
        if (iniciar) prox = LIMPA;
      end
      LIMPA: begin
        enable_load_aste = 1'b1;
        if (rco_contador_aste) begin
          reset_contador_aste = 1'b1;
          prox                = ESPERA;
        end else begin
          conta_contador_aste = 1'b1;
        end
      end
      ESPERA: begin
        if (iniciar)         prox = INICIAL;
        else if (tick_frame) prox = LE;
      end
      LE: begin
        if (!loaded_aste || destruido_aste) prox = PROXIMO;
        else                                prox = MOVE;
      end
      MOVE: begin
        select_mux_coor_aste = opcode_aste[1];
        select_soma_sub_aste = opcode_aste[0];
        select_mux_pos_aste  = {1'b0, opcode_aste[1]};
        enable_mem_aste      = 1'b1;
        prox                 = CHECA;
      end
      CHECA: begin
        if (colisao_aste_com_nave) prox = COLIDE;
        else                       prox = PROXIMO;
      end
      COLIDE: begin
`ifdef ASTE_COLISAO_DESTROI_EN
        enable_load_aste   = 1'b1;
        new_load_aste      = 1'b1;
        new_destruido_aste = 1'b1;
        dec_vidas          = 1'b1;
        prox               = (vidas_r <= 2'd1) ? GAME_OVER : PROXIMO;
`else
        prox = GAME_OVER;
`endif
      end
      PROXIMO: begin
        if (rco_contador_aste) begin
          reset_contador_aste = 1'b1;
          prox                = spawn_pend ? SP_LE : FIM;
        end else begin
          conta_contador_aste = 1'b1;
          prox                = LE;
        end
      end
      SP_LE: begin
        if (!loaded_aste) begin
          prox = SP_ROM;
        end else if (rco_contador_aste) begin
          limpa_spawn = 1'b1;
          prox        = FIM;
        end else begin
          conta_contador_aste = 1'b1;
        end
      end
      SP_ROM: prox = SP_ESCREVE;
      SP_ESCREVE: begin
        select_mux_pos_aste = POS_RANDOM;
        enable_mem_aste     = 1'b1;
        enable_load_aste    = 1'b1;
        new_load_aste       = 1'b1;
        limpa_spawn         = 1'b1;
        prox                = FIM;
      end
      FIM: begin
        pronto_frame        = 1'b1;
        reset_contador_aste = 1'b1;
        prox                = ESPERA;
      end
      GAME_OVER: begin
        fim_jogo = 1'b1;
        if (iniciar) prox = INICIAL;
      end
      default: prox = INICIAL;
    endcase
  end

endmodule
